// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: reset PC, fetch state encoding and the
// upstream PC-select codes from which npc_redirect is formed.
package fetch_ctrl_pkg;

  localparam logic [31:0] PC_RESET_VAL = 32'h0000_3000;

  // FsReq: request outstanding (or about to issue) at F_pc.
  // FsHeld: word for F_pc captured in the instruction buffer, waiting on D.
  typedef enum logic {
    FsReq  = 1'b0,
    FsHeld = 1'b1
  } fetch_state_e;

  // PC-select codes produced by the D-stage decoder for the npc unit.
  typedef enum logic [1:0] {
    PcSelSeq    = 2'd0,
    PcSelBranch = 2'd1,
    PcSelJump   = 2'd2,
    PcSelJr     = 2'd3
  } pc_sel_e;

  // A control transfer redirects fetch for jumps always, branches only when taken.
  function automatic logic is_redirect(pc_sel_e sel, logic br_taken);
    logic redir;
    redir = 1'b0;
    unique case (sel)
      PcSelSeq:    redir = 1'b0;
      PcSelBranch: redir = br_taken;
      PcSelJump:   redir = 1'b1;
      PcSelJr:     redir = 1'b1;
      default:     redir = 1'b0;
    endcase
    return redir;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: hazard/npc inputs, instruction memory handshake and
// the F-stage outputs towards the F/D pipeline register.
interface fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall;
  logic              npc_redirect;
  logic [ADDR_W-1:0] npc_target;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;
  logic [ADDR_W-1:0] F_pc;
  logic [31:0]       F_instr;
  logic              F_valid;
  logic              redir_overlap;

  // Fetch controller side.
  modport master (
    input  stall, npc_redirect, npc_target, imem_ready, imem_rdata,
    output imem_req, imem_addr, F_pc, F_instr, F_valid, redir_overlap
  );

  // Surrounding pipeline and memory side.
  modport slave (
    output stall, npc_redirect, npc_target, imem_ready, imem_rdata,
    input  imem_req, imem_addr, F_pc, F_instr, F_valid, redir_overlap
  );
endinterface

// File: rtl/fetch_ctrl.sv
// F-stage PC owner: sequences fetches against a variable-latency instruction
// memory, buffers a returned word while D is stalled, and keeps a redirect
// that arrives while the delay-slot fetch is still outstanding.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(PC_RESET_VAL)
) (
  input logic           clk,
  input logic           reset,
  fetch_ctrl_if.master  fif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_buf_q, instr_buf_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              overlap_q, overlap_d;

  logic valid;
  logic fire;
  logic redir;

  // F-stage outputs and the fire/redirect qualifiers.
  always_comb begin
    valid = !reset && ((state_q == FsHeld) || (state_q == FsReq && fif.imem_ready));
    fire  = valid && !fif.stall;
    // While stalled, D holds and will re-present its redirect.
    redir = fif.npc_redirect && !fif.stall;

    fif.imem_req      = (state_q == FsReq) && !reset;
    fif.imem_addr     = pc_q;
    fif.F_pc          = pc_q;
    fif.F_valid       = valid;
    fif.F_instr       = (state_q == FsHeld) ? instr_buf_q : fif.imem_rdata;
    fif.redir_overlap = overlap_q;
  end

  // Next-state: fetch sequencing, next-PC priority mux and pending redirect.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_buf_d = instr_buf_q;
    pend_v_d    = pend_v_q;
    pend_tgt_d  = pend_tgt_q;
    overlap_d   = overlap_q;

    // A second redirect before the first was consumed: newest target wins.
    if (redir && pend_v_q) begin
      overlap_d = 1'b1;
    end

    if (fire) begin
      state_d  = FsReq;
      pend_v_d = 1'b0;
      if (redir) begin
        pc_d = fif.npc_target;
      end else if (pend_v_q) begin
        pc_d = pend_tgt_q;
      end else begin
        pc_d = pc_q + ADDR_W'(4);
      end
    end else begin
      // Delay slot not issued yet; remember where to go after it.
      if (redir) begin
        pend_v_d   = 1'b1;
        pend_tgt_d = fif.npc_target;
      end
      if (state_q == FsReq && fif.imem_ready) begin
        state_d     = FsHeld;
        instr_buf_d = fif.imem_rdata;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FsReq;
      pc_q        <= PC_RESET;
      instr_buf_q <= '0;
      pend_v_q    <= 1'b0;
      pend_tgt_q  <= '0;
      overlap_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_buf_q <= instr_buf_d;
      pend_v_q    <= pend_v_d;
      pend_tgt_q  <= pend_tgt_d;
      overlap_q   <= overlap_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed plan steps followed by random traffic, all
// checked every cycle against a transaction-level model of the fetch rules.
module tb_fetch_ctrl;

  logic clk;
  logic reset;

  fetch_ctrl_if #(.ADDR_W(32)) fif ();

  fetch_ctrl #(
    .ADDR_W  (32),
    .PC_RESET(32'h0000_3000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .fif  (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  // Model: current PC, whether the word for it has been captured, and a
  // queue holding at most one deferred redirect target.
  logic [31:0] m_pc;
  bit          m_have;
  logic [31:0] m_word;
  logic [31:0] m_pend[$];
  bit          m_ovl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc   = 32'h0000_3000;
    m_have = 1'b0;
    m_word = 32'h0;
    m_pend.delete();
    m_ovl  = 1'b0;
  endtask

  // One clock: drive, check outputs mid-cycle, advance model at the edge.
  task automatic step(input bit rst, input bit st, input bit rd, input logic [31:0] tgt,
                      input bit rdy, input logic [31:0] data);
    bit exp_valid;
    bit fire;
    bit redir;
    reset             = rst;
    fif.stall         = st;
    fif.npc_redirect  = rd;
    fif.npc_target    = tgt;
    fif.imem_ready    = rdy;
    fif.imem_rdata    = data;
    @(negedge clk);
    exp_valid = !rst && (m_have || rdy);
    check("imem_req", 32'(fif.imem_req), 32'(!rst && !m_have));
    check("imem_addr", fif.imem_addr, m_pc);
    check("F_pc", fif.F_pc, m_pc);
    check("F_valid", 32'(fif.F_valid), 32'(exp_valid));
    if (exp_valid) check("F_instr", fif.F_instr, m_have ? m_word : data);
    check("redir_overlap", 32'(fif.redir_overlap), 32'(m_ovl));
    check("pend_v", 32'(dut.pend_v_q), 32'(m_pend.size() > 0));
    @(posedge clk);
    fire  = exp_valid && !st;
    redir = rd && !st;
    if (rst) begin
      model_reset();
    end else begin
      if (redir && m_pend.size() > 0) m_ovl = 1'b1;
      if (fire) begin
        if (redir) m_pc = tgt;
        else if (m_pend.size() > 0) m_pc = m_pend[0];
        else m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        m_pend.delete();
        m_have = 1'b0;
      end else begin
        if (redir) begin
          m_pend.delete();
          m_pend.push_back(tgt);
        end
        if (!m_have && rdy) begin
          m_have = 1'b1;
          m_word = data;
        end
      end
    end
    #1;
  endtask

  // Plain-constant cross-check of the fetch address after a step.
  task automatic expect_addr(input string tag, input logic [31:0] exp);
    check(tag, fif.imem_addr, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset            = 1'b1;
    fif.stall        = 1'b0;
    fif.npc_redirect = 1'b0;
    fif.npc_target   = 32'h0;
    fif.imem_ready   = 1'b0;
    fif.imem_rdata   = 32'h0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset cycle: no request, no valid, late ready ignored.
    step(1, 0, 0, 32'h0, 1, 32'hDEAD_0000);
    expect_addr("reset_addr", 32'h0000_3000);

    // Zero-wait: one instruction per cycle.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1, 32'hA000_0000 + i);
    expect_addr("zero_wait_4", 32'h0000_3010);

    // Two memory wait cycles at 0x3004.
    step(1, 0, 0, 32'h0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 1, 32'hB000_0000);
    step(0, 0, 0, 32'h0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 32'h0);
    expect_addr("wait_hold", 32'h0000_3004);
    step(0, 0, 0, 32'h0, 1, 32'hB000_0004);
    expect_addr("after_wait", 32'h0000_3008);

    // Data returns at 0x3008 under a 3-cycle stall, then released.
    step(0, 1, 0, 32'h0, 1, 32'hC000_3008);
    step(0, 1, 1, 32'h0000_7777, 1, 32'h1111_1111);
    step(0, 1, 0, 32'h0, 0, 32'h2222_2222);
    expect_addr("stall_hold", 32'h0000_3008);
    step(0, 0, 0, 32'h0, 0, 32'h3333_3333);
    expect_addr("stall_release", 32'h0000_300C);
    step(0, 0, 0, 32'h0, 1, 32'hC000_300C);

    // Delay slot at 0x3010 fires together with its redirect.
    step(0, 0, 1, 32'h0000_3100, 1, 32'hD000_3010);
    expect_addr("delay_slot", 32'h0000_3100);

    // Redirect to 0x3010, then a redirect captured while 0x3010 waits.
    step(0, 0, 1, 32'h0000_3010, 1, 32'hD000_3100);
    step(0, 0, 1, 32'h0000_3200, 0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 1, 32'hD001_3010);
    expect_addr("pending_apply", 32'h0000_3200);

    // Two captures before the slot issues: newest wins, overlap sticks.
    step(0, 0, 1, 32'h0000_4000, 0, 32'h0);
    step(0, 0, 1, 32'h0000_5000, 0, 32'h0);
    step(0, 0, 0, 32'h0, 1, 32'hE000_3200);
    expect_addr("overlap_newest", 32'h0000_5000);
    step(0, 0, 0, 32'h0, 1, 32'hE000_5000);

    // PC wraps from 0xFFFF_FFFC to 0.
    step(0, 0, 1, 32'hFFFF_FFFC, 1, 32'hF000_0000);
    step(0, 0, 0, 32'h0, 1, 32'hF000_FFFC);
    expect_addr("pc_wrap", 32'h0000_0000);

    // Reset while the fetch at 0 is outstanding; ready in reset is ignored.
    step(0, 0, 0, 32'h0, 0, 32'h0);
    step(1, 0, 0, 32'h0, 1, 32'hBAD0_BAD0);
    expect_addr("reset_mid_fetch", 32'h0000_3000);
    step(0, 0, 0, 32'h0, 1, 32'h1234_5678);

    // Random traffic, including misaligned targets and occasional reset.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = $urandom();
      if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
      step(($urandom_range(49) == 0), ($urandom_range(9) < 3), ($urandom_range(9) < 2), tgt,
           ($urandom_range(9) < 6), $urandom());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Owns the F-stage PC register and sequences instruction fetch against a variable-latency instruction memory.
- Consumes the D-stage next-PC result (target plus a redirect flag), applies stalls from the hazard unit, and presents F_pc/F_instr/F_valid to the F/D pipeline register.
- Remembers a redirect that arrives while the delay-slot fetch is still outstanding, so that no jump or branch is lost.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit hold of F/D; 1 = D must not advance.
- npc_redirect  in  1  D-stage control-transfer flag: jr, j/jal, or taken branch.
- npc_target  in  ADDR_W  D-stage computed target (next_pc from the npc unit).
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; always equals F_pc.
- imem_ready  in  1  memory returns imem_rdata this cycle for the outstanding request.
- imem_rdata  in  32  instruction word.
- F_pc  out  ADDR_W  PC of the instruction in F.
- F_instr  out  32  instruction word for F_pc; valid only when F_valid is 1.
- F_valid  out  1  F_instr is available to D this cycle.
- redir_overlap  out  1  sticky error flag: a new redirect arrived while one was already pending.

Behaviour:
- Registered state: F_pc, state (S_REQ, S_HELD), instr_buf[31:0], pend_v, pend_tgt, redir_overlap.
- Reset, in the same edge: F_pc = PC_RESET, state = S_REQ, pend_v = 0, instr_buf = 0, redir_overlap = 0.
- During the reset cycle imem_req = 0 and F_valid = 0; an imem_ready seen in that cycle is ignored.
- Reset asserted mid-fetch abandons the outstanding request; fetch restarts at PC_RESET.
- imem_req = (state == S_REQ) && !reset. imem_addr = F_pc, held stable until imem_ready.
- F_valid (combinational) = (state == S_HELD) || (state == S_REQ && imem_ready).
- F_instr = (state == S_HELD) ? instr_buf : imem_rdata.
- fire = F_valid && !stall. On fire, D latches F_pc/F_instr.
- S_REQ transitions:
  - imem_ready && !fire → S_HELD, instr_buf <= imem_rdata.
  - fire → stay in S_REQ with the new F_pc.
  - otherwise hold.
- S_HELD transitions: fire → S_REQ with the new F_pc; otherwise hold, with instr_buf frozen.
- New F_pc on fire, in priority order:
  - npc_redirect → npc_target;
  - else pend_v → pend_tgt (and pend_v <= 0);
  - else F_pc + 4, modulo 2^ADDR_W (0xFFFF_FFFC wraps to 0).
- Delay-slot semantics: the instruction in F when a redirect is seen is the delay slot; it always issues, and the redirect applies only to the fetch after it.
- Redirect is meaningful only when !stall. If stall = 1, npc_redirect is ignored, because D holds and will re-present it.
- If !stall && npc_redirect && !fire: pend_v <= 1, pend_tgt <= npc_target. D receives a bubble and the branch leaves D.
- If pend_v is already 1 when a capture or apply occurs: the new npc_target wins and redir_overlap <= 1, sticky until reset.
- Zero-wait memory (imem_ready always 1, stall 0) gives 1 instruction per cycle. Each memory wait cycle adds one F bubble.
- Misaligned targets (low 2 bits ≠ 0) are passed through unchanged; exception handling is outside this block.

Decomposition:
- Shared defines file gets PC_RESET_VAL, the fetch state encodings (FS_REQ, FS_HELD), and the existing PCSel codes used to form npc_redirect upstream.
- No sub-module needed: the next-PC priority mux is inline. The npc unit stays external and feeds npc_target.

Test Plan:
- Reset, then imem_ready = 1 and stall = 0 for 4 cycles → imem_addr = 3000, 3004, 3008, 300C on consecutive cycles; F_valid = 1 each cycle.
- imem_ready = 0 for 2 cycles at 0x3004 → imem_addr holds 3004 and F_valid = 0 for 2 cycles, then 3004 fires and 3008 follows.
- Data returns at 0x3008 while stall = 1 for 3 cycles → state S_HELD, F_instr = buffered word, no new request; on release 3008 fires, next addr 300C.
- Delay slot 0x3010 fires with npc_redirect = 1 and npc_target = 0x3100 → next imem_addr = 3100, never 3014.
- npc_redirect = 1, target 0x3200, while the 0x3010 fetch waits 2 cycles → pend_v = 1; 3010 fires, next addr 3200; pend_v = 0.
- F_pc = 0xFFFF_FFFC fires with no redirect → next 0x0000_0000. reset asserted while a fetch is outstanding → next addr 3000; a late imem_ready is ignored.
